// File: rtl/fgseq_pkg.sv
// Shared types and entry layout for the FuncGen playlist sequencer.
// An entry is {wave_sel, amp_sel, cnt_load, duration}, MSB to LSB.
package fgseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int WAVE_W = 3;
    localparam int AMP_W  = 2;
    localparam int CNT_W  = 5;
    localparam int META_W = WAVE_W + AMP_W + CNT_W;

    localparam logic [CNT_W-1:0] CNT_LOAD_RST = 5'b11111;

    // Field offsets measured from the top of the duration field.
    localparam int CNT_OFS  = 0;
    localparam int AMP_OFS  = CNT_W;
    localparam int WAVE_OFS = CNT_W + AMP_W;

endpackage

// File: rtl/fgseq_playlist_ram.sv
// Playlist storage: DEPTH x W register file, synchronous write,
// combinational read.
module fgseq_playlist_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 26
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately left out of reset; every entry is
    // written before use, and a reset here would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/func_gen_sequencer.sv
// Playlist controller driving FuncGen's ld/cnt_load/wave_sel/amp_sel.
// Optional `FGSEQ_LOOP_EN enables replay of the playlist while loop=1.
module func_gen_sequencer
    import fgseq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DUR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [META_W+DUR_W-1:0] wr_data,
    input  logic [AW:0]             len,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    output logic                    ld,
    output logic [CNT_W-1:0]        cnt_load,
    output logic [WAVE_W-1:0]       wave_sel,
    output logic [AMP_W-1:0]        amp_sel,
    output logic [AW-1:0]           step,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_reject
);

    localparam int EW = META_W + DUR_W;

    state_t             state_q, state_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic               fin_q, fin_d;
    logic               ld_q, ld_d;
    logic [CNT_W-1:0]   cnt_load_q, cnt_load_d;
    logic [WAVE_W-1:0]  wave_sel_q, wave_sel_d;
    logic [AMP_W-1:0]   amp_sel_q, amp_sel_d;
    logic [AW-1:0]      step_q, step_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_reject_q, wr_reject_d;

    logic [EW-1:0]      rd_entry;
    logic [DUR_W-1:0]   rd_dur;
    logic               last_step;

    fgseq_playlist_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && (state_q == IDLE)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (step_q),
        .rdata (rd_entry)
    );

    assign rd_dur = rd_entry[DUR_W-1:0];

    // Compared as step+1 >= len so that a len lowered to 0 mid-play still ends.
    assign last_step = (({1'b0, step_q} + (AW+1)'(1)) >= len);

`ifndef FGSEQ_LOOP_EN
    logic loop_unused;
    assign loop_unused = loop;
`endif

    // NOTE: every *_d gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        dur_cnt_d   = dur_cnt_q;
        fin_d       = 1'b0;
        ld_d        = 1'b0;
        cnt_load_d  = cnt_load_q;
        wave_sel_d  = wave_sel_q;
        amp_sel_d   = amp_sel_q;
        step_d      = step_q;
        done_d      = fin_q;
        wr_reject_d = wr_en && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    step_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_d       = 1'b1;
                cnt_load_d = rd_entry[DUR_W+CNT_OFS  +: CNT_W];
                amp_sel_d  = rd_entry[DUR_W+AMP_OFS  +: AMP_W];
                wave_sel_d = rd_entry[DUR_W+WAVE_OFS +: WAVE_W];
                dur_cnt_d  = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                state_d    = HOLD;
            end
            HOLD: begin
                if (dur_cnt_q > DUR_W'(1)) begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                end else if (!last_step) begin
                    step_d  = step_q + AW'(1);
                    state_d = LOAD;
                end else begin
`ifdef FGSEQ_LOOP_EN
                    if (loop) begin
                        step_d  = '0;
                        state_d = LOAD;
                    end else begin
                        fin_d   = 1'b1;
                        state_d = IDLE;
                    end
`else
                    fin_d   = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // stop wins over start, expiry and a pending done.
        if (stop) begin
            state_d    = IDLE;
            dur_cnt_d  = dur_cnt_q;
            fin_d      = 1'b0;
            ld_d       = 1'b0;
            done_d     = 1'b0;
            cnt_load_d = cnt_load_q;
            wave_sel_d = wave_sel_q;
            amp_sel_d  = amp_sel_q;
            step_d     = step_q;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dur_cnt_q   <= '0;
            fin_q       <= 1'b0;
            ld_q        <= 1'b0;
            cnt_load_q  <= CNT_LOAD_RST;
            wave_sel_q  <= '0;
            amp_sel_q   <= '0;
            step_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dur_cnt_q   <= dur_cnt_d;
            fin_q       <= fin_d;
            ld_q        <= ld_d;
            cnt_load_q  <= cnt_load_d;
            wave_sel_q  <= wave_sel_d;
            amp_sel_q   <= amp_sel_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    assign ld        = ld_q;
    assign cnt_load  = cnt_load_q;
    assign wave_sel  = wave_sel_q;
    assign amp_sel   = amp_sel_q;
    assign step      = step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_reject = wr_reject_q;

endmodule

// File: tb/tb_func_gen_sequencer.sv
// Directed self-checking bench for func_gen_sequencer; build with
// +define+FGSEQ_LOOP_EN to exercise the looping variant.
module tb_func_gen_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DUR_W = 16;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [10+DUR_W-1:0] wr_data;
    logic [AW:0]       len;
    logic              start;
    logic              stop;
    logic              loop;
    logic              ld;
    logic [4:0]        cnt_load;
    logic [2:0]        wave_sel;
    logic [1:0]        amp_sel;
    logic [AW-1:0]     step;
    logic              busy;
    logic              done;
    logic              wr_reject;

    int n_checks = 0;
    int n_fail   = 0;

    func_gen_sequencer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DUR_W (DUR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .ld        (ld),
        .cnt_load  (cnt_load),
        .wave_sel  (wave_sel),
        .amp_sel   (amp_sel),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .wr_reject (wr_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int wv, input int amp, input int cnt, input int dur);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {3'(wv), 2'(amp), 5'(cnt), 16'(dur)};
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_fields(input string tag, input int wv, input int amp, input int cnt, input int st);
        check({tag, "_wave"}, 32'(wave_sel), 32'(wv));
        check({tag, "_amp"},  32'(amp_sel),  32'(amp));
        check({tag, "_cnt"},  32'(cnt_load), 32'(cnt));
        check({tag, "_step"}, 32'(step),     32'(st));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic exp_ld;
        logic exp_done;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_ld", 32'(ld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_reject", 32'(wr_reject), 0);
        check_fields("rst", 0, 0, 31, 0);

        // start with len=0 is ignored
        len = '0;
        pulse_start();
        tick();
        check("len0_busy", 32'(busy), 0);
        check("len0_ld", 32'(ld), 0);

        // Three-entry playback: ld at 1, 6, 9; done at 11
        wr(0, 0, 0, 31, 4);
        wr(1, 2, 2, 15, 2);
        wr(2, 5, 1, 7, 0);
        len = 4'd3;
        pulse_start();
        for (int r = 1; r <= 12; r++) begin
            tick();
            check("p3_ld", 32'(ld), 32'(r == 1 || r == 6 || r == 9));
            check("p3_done", 32'(done), 32'(r == 11));
            if (r == 1) check_fields("p3_e0", 0, 0, 31, 0);
            if (r == 2) check("p3_busy", 32'(busy), 1);
            if (r == 6) check_fields("p3_e1", 2, 2, 15, 1);
            if (r == 9) check_fields("p3_e2", 5, 1, 7, 2);
        end
        check("p3_idle_busy", 32'(busy), 0);

        // Abort during HOLD of entry 1
        pulse_start();
        for (int r = 1; r <= 6; r++) tick();
        check("ab_ld6", 32'(ld), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_ld", 32'(ld), 0);
        check_fields("ab_hold", 2, 2, 15, 1);
        for (int r = 0; r < 4; r++) begin
            tick();
            check("ab_no_done", 32'(done), 0);
            check("ab_no_ld", 32'(ld), 0);
        end

        // Restart from step 0 with a rejected write to entry 1 while busy
        pulse_start();
        for (int r = 1; r <= 12; r++) begin
            tick();
            check("bw_ld", 32'(ld), 32'(r == 1 || r == 6 || r == 9));
            check("bw_done", 32'(done), 32'(r == 11));
            if (r == 1) check_fields("bw_e0", 0, 0, 31, 0);
            if (r == 2) begin
                wr_en   = 1'b1;
                wr_addr = AW'(1);
                wr_data = {3'd7, 2'd3, 5'd1, 16'd9};
            end
            if (r == 3) begin
                wr_en = 1'b0;
                check("bw_reject", 32'(wr_reject), 1);
            end
            if (r == 4) check("bw_reject_clr", 32'(wr_reject), 0);
            if (r == 6) check_fields("bw_e1", 2, 2, 15, 1);
        end

        // Duration 0 acts as 1: done two cycles after ld
        wr(0, 3, 3, 9, 0);
        len = 4'd1;
        pulse_start();
        for (int r = 1; r <= 4; r++) begin
            tick();
            check("d0_ld", 32'(ld), 32'(r == 1));
            check("d0_done", 32'(done), 32'(r == 3));
            if (r == 1) check_fields("d0", 3, 3, 9, 0);
        end

        // Two-entry playlist with loop requested
        wr(0, 0, 0, 31, 4);
        len  = 4'd2;
        loop = 1'b1;
        pulse_start();
        for (int r = 1; r <= 18; r++) begin
            tick();
`ifdef FGSEQ_LOOP_EN
            exp_ld   = (r == 1 || r == 6 || r == 9 || r == 14);
            exp_done = (r == 17);
            if (r == 9) check_fields("lp_wrap", 0, 0, 31, 0);
`else
            exp_ld   = (r == 1 || r == 6);
            exp_done = (r == 9);
`endif
            check("lp_ld", 32'(ld), 32'(exp_ld));
            check("lp_done", 32'(done), 32'(exp_done));
            if (r == 9) loop = 1'b0;
        end
        check("lp_idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
